// File: rtl/bridge_dataslot_target_reader.sv
// Core-side initiator for the APF target_dataslot_read command: latches one request, issues it
// to the bridge target-command registers and reports the host's result. Optional watchdog:
// DATASLOT_READER_TIMEOUT_EN.
module bridge_dataslot_target_reader #(
  parameter int unsigned TIMEOUT_CYCLES = 32'd100_000_000
) (
  input  logic        clk_i,
  input  logic        reset_i,
  input  logic        req_valid_i,
  output logic        req_ready_o,
  input  logic [15:0] req_slot_id_i,
  input  logic [31:0] req_slot_offset_i,
  input  logic [31:0] req_bridge_addr_i,
  input  logic [31:0] req_length_i,
  output logic [15:0] target_cmd_o,
  output logic [31:0] target_param0_o,
  output logic [31:0] target_param1_o,
  output logic [31:0] target_param2_o,
  output logic [31:0] target_param3_o,
  output logic        target_trig_o,
  input  logic        target_ack_i,
  input  logic        target_done_i,
  input  logic [3:0]  target_result_i,
  output logic        busy_o,
  output logic        rsp_valid_o,
  output logic [3:0]  rsp_result_o
);

  typedef enum logic [2:0] {StIdle, StTrig, StWaitAck, StWaitDone, StResp} state_e;

  localparam logic [15:0] CmdDataslotRead = 16'h0180;
  localparam logic [3:0]  ResultTimeout   = 4'hF;

  state_e      state_q, state_d;
  logic [15:0] slot_id_q, slot_id_d;
  logic [31:0] offset_q, offset_d;
  logic [31:0] addr_q, addr_d;
  logic [31:0] length_q, length_d;
  logic [3:0]  rsp_result_q, rsp_result_d;
  logic        timeout_hit;

`ifdef DATASLOT_READER_TIMEOUT_EN
  logic [31:0] cnt_q, cnt_d;

  // Fires on the edge where the count would reach TIMEOUT_CYCLES, so RESP lands
  // TIMEOUT_CYCLES + 1 cycles after the trigger cycle.
  assign timeout_hit = (state_q == StWaitAck || state_q == StWaitDone) &&
                       (cnt_q == TIMEOUT_CYCLES - 32'd1);

  always_comb begin
    cnt_d = cnt_q;
    if (state_q == StTrig) begin
      cnt_d = '0;
    end else if (state_q == StWaitAck || state_q == StWaitDone) begin
      cnt_d = cnt_q + 32'd1;
    end
  end

  always_ff @(posedge clk_i or posedge reset_i) begin
    if (reset_i) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end
`else
  logic unused_timeout_cycles;
  assign unused_timeout_cycles = ^TIMEOUT_CYCLES;
  assign timeout_hit = 1'b0;
`endif

  always_comb begin
    state_d      = state_q;
    slot_id_d    = slot_id_q;
    offset_d     = offset_q;
    addr_d       = addr_q;
    length_d     = length_q;
    rsp_result_d = rsp_result_q;
    case (state_q)
      StIdle: begin
        if (req_valid_i) begin
          slot_id_d = req_slot_id_i;
          offset_d  = req_slot_offset_i;
          addr_d    = req_bridge_addr_i;
          length_d  = req_length_i;
          state_d   = StTrig;
        end
      end
      StTrig: state_d = StWaitAck;
      StWaitAck: begin
        // A done without ack is not trusted; only a joint ack+done shortcuts to RESP.
        if (target_ack_i && target_done_i) begin
          rsp_result_d = target_result_i;
          state_d      = StResp;
        end else if (target_ack_i) begin
          state_d = StWaitDone;
        end else if (timeout_hit) begin
          rsp_result_d = ResultTimeout;
          state_d      = StResp;
        end
      end
      StWaitDone: begin
        if (target_done_i) begin
          rsp_result_d = target_result_i;
          state_d      = StResp;
        end else if (timeout_hit) begin
          rsp_result_d = ResultTimeout;
          state_d      = StResp;
        end
      end
      StResp:  state_d = StIdle;
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk_i or posedge reset_i) begin
    if (reset_i) begin
      state_q      <= StIdle;
      slot_id_q    <= '0;
      offset_q     <= '0;
      addr_q       <= '0;
      length_q     <= '0;
      rsp_result_q <= '0;
    end else begin
      state_q      <= state_d;
      slot_id_q    <= slot_id_d;
      offset_q     <= offset_d;
      addr_q       <= addr_d;
      length_q     <= length_d;
      rsp_result_q <= rsp_result_d;
    end
  end

  assign req_ready_o     = (state_q == StIdle) && !reset_i;
  assign busy_o          = (state_q != StIdle);
  assign target_cmd_o    = busy_o ? CmdDataslotRead : 16'h0000;
  assign target_trig_o   = (state_q == StTrig);
  assign rsp_valid_o     = (state_q == StResp);
  assign rsp_result_o    = rsp_result_q;
  assign target_param0_o = {16'h0000, slot_id_q};
  assign target_param1_o = offset_q;
  assign target_param2_o = addr_q;
  assign target_param3_o = length_q;

endmodule

// File: tb/tb_bridge_dataslot_target_reader.sv
// Directed bench for bridge_dataslot_target_reader; timeout scenario only when
// DATASLOT_READER_TIMEOUT_EN is defined.
module tb_bridge_dataslot_target_reader;

  logic        clk_i = 1'b0;
  logic        reset_i = 1'b1;
  logic        req_valid_i = 1'b0;
  logic        req_ready_o;
  logic [15:0] req_slot_id_i = '0;
  logic [31:0] req_slot_offset_i = '0;
  logic [31:0] req_bridge_addr_i = '0;
  logic [31:0] req_length_i = '0;
  logic [15:0] target_cmd_o;
  logic [31:0] target_param0_o, target_param1_o, target_param2_o, target_param3_o;
  logic        target_trig_o;
  logic        target_ack_i = 1'b0;
  logic        target_done_i = 1'b0;
  logic [3:0]  target_result_i = '0;
  logic        busy_o;
  logic        rsp_valid_o;
  logic [3:0]  rsp_result_o;

  int total = 0;
  int bad   = 0;

  bridge_dataslot_target_reader #(
    .TIMEOUT_CYCLES(50)
  ) dut (
    .clk_i            (clk_i),
    .reset_i          (reset_i),
    .req_valid_i      (req_valid_i),
    .req_ready_o      (req_ready_o),
    .req_slot_id_i    (req_slot_id_i),
    .req_slot_offset_i(req_slot_offset_i),
    .req_bridge_addr_i(req_bridge_addr_i),
    .req_length_i     (req_length_i),
    .target_cmd_o     (target_cmd_o),
    .target_param0_o  (target_param0_o),
    .target_param1_o  (target_param1_o),
    .target_param2_o  (target_param2_o),
    .target_param3_o  (target_param3_o),
    .target_trig_o    (target_trig_o),
    .target_ack_i     (target_ack_i),
    .target_done_i    (target_done_i),
    .target_result_i  (target_result_i),
    .busy_o           (busy_o),
    .rsp_valid_o      (rsp_valid_o),
    .rsp_result_o     (rsp_result_o)
  );

  always #5 clk_i = ~clk_i;

  task automatic tick();
    @(posedge clk_i);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic set_req(input logic [15:0] id, input logic [31:0] off, input logic [31:0] addr,
                         input logic [31:0] len);
    req_slot_id_i     = id;
    req_slot_offset_i = off;
    req_bridge_addr_i = addr;
    req_length_i      = len;
  endtask

  task automatic check_idle_zero(input string tag);
    check({tag, "_busy"}, {31'd0, busy_o}, 32'd0);
    check({tag, "_cmd"}, {16'd0, target_cmd_o}, 32'd0);
    check({tag, "_trig"}, {31'd0, target_trig_o}, 32'd0);
    check({tag, "_rspv"}, {31'd0, rsp_valid_o}, 32'd0);
    check({tag, "_rspr"}, {28'd0, rsp_result_o}, 32'd0);
    check({tag, "_p0"}, target_param0_o, 32'd0);
    check({tag, "_p1"}, target_param1_o, 32'd0);
    check({tag, "_p2"}, target_param2_o, 32'd0);
    check({tag, "_p3"}, target_param3_o, 32'd0);
    check({tag, "_ready"}, {31'd0, req_ready_o}, 32'd0);
  endtask

  initial begin
    logic seen;
    int   lat;

    // Reset state
    #1;
    check_idle_zero("rst");
    tick();
    tick();
    reset_i = 1'b0;
    #1;
    check("rst_rel_ready", {31'd0, req_ready_o}, 32'd1);

    // 1: basic command, ack at +5, done at +20, result 0
    set_req(16'h0003, 32'h100, 32'h1000_0000, 32'h400);
    req_valid_i = 1'b1;
    tick();                                  // accepted at N, now in N+1
    req_valid_i = 1'b0;
    check("t1_trig", {31'd0, target_trig_o}, 32'd1);
    check("t1_busy", {31'd0, busy_o}, 32'd1);
    check("t1_cmd", {16'd0, target_cmd_o}, 32'h0180);
    check("t1_ready", {31'd0, req_ready_o}, 32'd0);
    check("t1_p0", target_param0_o, 32'h0000_0003);
    check("t1_p1", target_param1_o, 32'h0000_0100);
    check("t1_p2", target_param2_o, 32'h1000_0000);
    check("t1_p3", target_param3_o, 32'h0000_0400);
    tick();
    check("t1_trig_once", {31'd0, target_trig_o}, 32'd0);
    tick();
    tick();
    tick();
    target_ack_i = 1'b1;                     // N+5
    seen = 1'b0;
    for (int i = 0; i < 15; i++) begin
      tick();
      if (rsp_valid_o || !busy_o) seen = 1'b1;
    end
    check("t1_no_early_rsp", {31'd0, seen}, 32'd0);
    target_done_i   = 1'b1;                  // N+20
    target_result_i = 4'h0;
    tick();
    check("t1_rspv", {31'd0, rsp_valid_o}, 32'd1);
    check("t1_rspr", {28'd0, rsp_result_o}, 32'd0);
    target_ack_i  = 1'b0;
    target_done_i = 1'b0;
    tick();
    check("t1_rspv_once", {31'd0, rsp_valid_o}, 32'd0);
    check("t1_ready_back", {31'd0, req_ready_o}, 32'd1);
    check("t1_cmd_clear", {16'd0, target_cmd_o}, 32'd0);
    check("t1_p1_held", target_param1_o, 32'h0000_0100);

    // 2: ack+done together, result 2, zero length, minimum latency
    set_req(16'h0005, 32'h20, 32'h2000_0000, 32'h0);
    req_valid_i = 1'b1;
    tick();                                  // N+1 (TRIG)
    req_valid_i     = 1'b0;
    target_ack_i    = 1'b1;                  // ignored in TRIG, sampled at N+2
    target_done_i   = 1'b1;
    target_result_i = 4'h2;
    check("t2_p3_zero", target_param3_o, 32'd0);
    tick();                                  // N+2
    check("t2_not_yet", {31'd0, rsp_valid_o}, 32'd0);
    tick();                                  // N+3
    check("t2_rspv", {31'd0, rsp_valid_o}, 32'd1);
    check("t2_rspr", {28'd0, rsp_result_o}, 32'd2);
    target_ack_i  = 1'b0;
    target_done_i = 1'b0;
    tick();
    check("t2_idle", {31'd0, busy_o}, 32'd0);

    // 3: requester holds valid through a busy command, then changes to new params
    set_req(16'h0007, 32'h700, 32'h7000_0000, 32'h70);
    req_valid_i = 1'b1;
    tick();                                  // N+1 (TRIG with A)
    set_req(16'h0009, 32'h900, 32'h9000_0000, 32'h90);
    check("t3_ready_busy", {31'd0, req_ready_o}, 32'd0);
    check("t3_p0_A", target_param0_o, 32'h7);
    target_ack_i    = 1'b1;
    target_done_i   = 1'b1;
    target_result_i = 4'h3;
    tick();
    tick();                                  // RESP
    check("t3_rspv", {31'd0, rsp_valid_o}, 32'd1);
    check("t3_rspr", {28'd0, rsp_result_o}, 32'd3);
    check("t3_p2_A_held", target_param2_o, 32'h7000_0000);
    target_ack_i  = 1'b0;
    target_done_i = 1'b0;
    tick();                                  // IDLE, accepts B at next edge
    check("t3_ready_idle", {31'd0, req_ready_o}, 32'd1);
    tick();                                  // TRIG with B
    req_valid_i = 1'b0;
    check("t3_trig_B", {31'd0, target_trig_o}, 32'd1);
    check("t3_p0_B", target_param0_o, 32'h9);
    check("t3_p1_B", target_param1_o, 32'h900);
    check("t3_p2_B", target_param2_o, 32'h9000_0000);
    check("t3_p3_B", target_param3_o, 32'h90);
    target_ack_i    = 1'b1;
    target_done_i   = 1'b1;
    target_result_i = 4'h4;
    tick();
    tick();
    check("t3_rspr_B", {28'd0, rsp_result_o}, 32'd4);
    target_ack_i  = 1'b0;
    target_done_i = 1'b0;
    tick();

    // 4: reset in WAIT_DONE abandons the command
    set_req(16'h000A, 32'hA0, 32'hA000_0000, 32'hA);
    req_valid_i = 1'b1;
    tick();                                  // TRIG
    req_valid_i = 1'b0;
    tick();                                  // WAIT_ACK
    target_ack_i = 1'b1;
    tick();                                  // WAIT_DONE
    check("t4_busy", {31'd0, busy_o}, 32'd1);
    reset_i = 1'b1;
    #1;
    check_idle_zero("t4_rst");
    target_done_i   = 1'b1;
    target_result_i = 4'h7;
    tick();
    tick();
    reset_i       = 1'b0;
    target_ack_i  = 1'b0;
    target_done_i = 1'b0;
    seen = 1'b0;
    for (int i = 0; i < 4; i++) begin
      tick();
      if (rsp_valid_o || busy_o) seen = 1'b1;
    end
    check("t4_no_rsp", {31'd0, seen}, 32'd0);
    set_req(16'h000B, 32'hB0, 32'hB000_0000, 32'hB);
    req_valid_i = 1'b1;
    tick();
    req_valid_i = 1'b0;
    tick();
    target_ack_i = 1'b1;
    tick();
    target_done_i   = 1'b1;
    target_result_i = 4'h5;
    tick();
    check("t4_after_rspv", {31'd0, rsp_valid_o}, 32'd1);
    check("t4_after_rspr", {28'd0, rsp_result_o}, 32'd5);
    target_ack_i  = 1'b0;
    target_done_i = 1'b0;
    tick();

    // 5: ack/done seen in IDLE are ignored
    target_ack_i    = 1'b1;
    target_done_i   = 1'b1;
    target_result_i = 4'h6;
    seen = 1'b0;
    for (int i = 0; i < 3; i++) begin
      tick();
      if (rsp_valid_o || busy_o) seen = 1'b1;
    end
    target_ack_i  = 1'b0;
    target_done_i = 1'b0;
    check("t5_no_rsp", {31'd0, seen}, 32'd0);
    check("t5_rspr_kept", {28'd0, rsp_result_o}, 32'd5);
    check("t5_ready", {31'd0, req_ready_o}, 32'd1);

`ifdef DATASLOT_READER_TIMEOUT_EN
    // 6: never acked, timeout after 50 cycles in the wait states
    set_req(16'h000C, 32'hC0, 32'hC000_0000, 32'hC);
    req_valid_i = 1'b1;
    tick();                                  // trig cycle
    req_valid_i = 1'b0;
    check("t6_trig", {31'd0, target_trig_o}, 32'd1);
    lat = 0;
    for (int i = 1; i <= 200; i++) begin
      tick();
      if (rsp_valid_o) begin
        lat = i;
        break;
      end
    end
    check("t6_latency", lat, 32'd51);
    check("t6_rspr", {28'd0, rsp_result_o}, 32'hF);
    tick();
`else
    lat = 0;
`endif

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/bridge_dataslot_target_reader.md
# bridge_dataslot_target_reader

Core-side initiator for the APF `target_dataslot_read` command: the core asks the host to copy a byte range of a loaded dataslot into core memory over the bridge. This is the opposite direction to the host-driven dataslot write monitoring. The block latches one request, presents the command word and parameter struct to the target-command register file, then tracks the host's ack/done handshake and returns a result code. It sits between core loaders and the bridge target-command registers.

## Interface
- `TIMEOUT_CYCLES`, default 32'd100_000_000: cycles allowed from trigger to done before a timeout is forced (only used when the timeout feature is compiled in).
- `clk`  in  1  bridge-domain clock.
- `reset`  in  1  asynchronous, active-high reset.
- `req_valid`  in  1  request strobe.
- `req_ready`  out  1  high only in IDLE.
- `req_slot_id`  in  16  dataslot ID.
- `req_slot_offset`  in  32  byte offset within the slot.
- `req_bridge_addr`  in  32  destination bridge address.
- `req_length`  in  32  byte count.
- `target_cmd`  out  16  command word: 16'h0180 while busy, 0 otherwise.
- `target_param0..3`  out  32 each  {16'h0,slot_id}, offset, bridge_addr, length.
- `target_trig`  out  1  one-cycle pulse that issues the command.
- `target_ack`  in  1  host acknowledge, a level.
- `target_done`  in  1  host completion, a level.
- `target_result`  in  4  host result code, valid while `target_done` is high.
- `busy`  out  1  high in every state except IDLE.
- `rsp_valid`  out  1  one-cycle completion pulse.
- `rsp_result`  out  4  result code, held until the next `rsp_valid`.

## Operation
- States: IDLE, TRIG, WAIT_ACK, WAIT_DONE, RESP.
- IDLE: accepts a request when `req_valid & req_ready`.
  - Latches all four request fields into the param registers.
  - Moves to TRIG.
- TRIG: asserts `target_trig` for exactly one cycle, then moves to WAIT_ACK.
- WAIT_ACK: waits for `target_ack`, then moves to WAIT_DONE.
  - If `target_ack` and `target_done` rise together, goes straight to RESP and captures `target_result`.
- WAIT_DONE: on `target_done`, captures `target_result` into `rsp_result` and moves to RESP.
- RESP: pulses `rsp_valid` for one cycle, then returns to IDLE.
- Param registers hold their values from acceptance until the next accept, so the host can read them at any point during the command.
- A request arriving while busy is not accepted (`req_ready` = 0); the requester holds it.
- A `target_ack` or `target_done` seen in IDLE or TRIG is ignored; no spurious response is generated.
- Zero `req_length` is passed through unchanged; the host decides the result.
- Reset values: state IDLE, `target_cmd` 0, params 0, `target_trig` 0, `busy` 0, `rsp_valid` 0, `rsp_result` 0, `req_ready` 0 while `reset` is asserted.
- Reset mid-command abandons the command: outputs return to reset values and no `rsp_valid` is produced.

## Timing
- Acceptance at edge N: `target_trig` is high in cycle N+1 only. `busy` and `target_cmd` = 16'h0180 from N+1.
- `target_ack` sampled high at edge M (M ≥ N+2) moves the FSM to WAIT_DONE.
- `target_done` sampled high at edge K: `rsp_valid` and the new `rsp_result` are valid in cycle K+1. Back in IDLE with `req_ready` = 1 at K+2.
- Minimum issue-to-response latency: 3 cycles (ack and done both high at N+2).
- `target_ack` and `target_done` are assumed already synchronised to `clk`.

## Configuration
- `DATASLOT_READER_TIMEOUT_EN` defined:
  - A 32-bit counter clears on `target_trig` and increments in WAIT_ACK/WAIT_DONE.
  - When it reaches `TIMEOUT_CYCLES`, the FSM enters RESP with `rsp_result` = 4'hF.
  - A `target_done` in the same cycle as the timeout wins, and its result is reported.
- Not defined: no counter is built, and WAIT_ACK/WAIT_DONE wait indefinitely.

## Test plan
- Request slot 16'h0003, offset 32'h100, addr 32'h1000_0000, len 32'h400 → params hold those values, one-cycle trig, `target_cmd` 16'h0180. Ack at +5 and done at +20 with result 0 → `rsp_valid` one cycle later, `rsp_result` 0.
- Ack and done high in the same cycle, result 4'h2 → RESP directly, `rsp_result` 2, 3-cycle minimum latency.
- Second `req_valid` held throughout a busy command → not accepted until `req_ready` returns; then accepted with the new params.
- Assert `reset` in WAIT_DONE → all outputs zero immediately, no `rsp_valid`. After release, a new request completes normally.
- Pulse `target_done` in IDLE → no `rsp_valid`, state unchanged.
- With `DATASLOT_READER_TIMEOUT_EN` and `TIMEOUT_CYCLES` = 50, never ack → `rsp_result` 4'hF, `rsp_valid` 51 cycles after trig.
